// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the MIPS32 instruction-fetch stage.
package fetch_unit_pkg;

  localparam logic [5:0]  OP_J    = 6'b000010;
  localparam logic [5:0]  OP_JAL  = 6'b000011;
  localparam logic [31:0] NOP_INS = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic is_jump(input logic [31:0] ins);
    return (ins[31:26] == OP_J) || (ins[31:26] == OP_JAL);
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [31:0] ins);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    return {pc4[31:28], ins[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry {ins, pc} FIFO. The head is a plain register so the outputs come
// straight from flops; an empty head reads NOP and keeps the last popped PC.
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         valid_o,
  output logic [31:0]  ins_o,
  output logic [31:0]  pc_o,
  output logic [1:0]   count_o
);

  fetch_entry_t head_q, head_d;
  fetch_entry_t tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [31:0]  last_pc_q, last_pc_d;
  logic         pop_ok, push_ok;

  assign pop_ok  = pop_i && (cnt_q != 2'd0);
  assign push_ok = push_i && (cnt_q != 2'd2);

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    last_pc_d = last_pc_q;
    if (flush_i) begin
      // a pop in the same cycle is discarded, so the last popped PC is unchanged
      cnt_d      = 2'd0;
      head_d.ins = NOP_INS;
      head_d.pc  = last_pc_q;
    end else begin
      if (pop_ok) last_pc_d = head_q.pc;
      unique case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt_q == 2'd0) head_d = push_data_i;
          else               tail_d = push_data_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd2) head_d     = tail_q;
          else               head_d.ins = NOP_INS;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11:   head_d = push_data_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '{ins: NOP_INS, pc: RESET_PC};
      tail_q    <= '0;
      cnt_q     <= 2'd0;
      last_pc_q <= RESET_PC;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      last_pc_q <= last_pc_d;
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign ins_o   = head_q.ins;
  assign pc_o    = head_q.pc;
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// MIPS32 instruction-fetch stage: PC, imem req/ack FSM and a 2-entry output buffer.
// Define FETCH_JUMP_EN to follow J/JAL targets at fetch time.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_ins,
  output logic [31:0] o_pc
);

  localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic [31:0]  tgt_pc, seq_pc;
  logic         push, pop;
  logic [1:0]   buf_cnt, post_cnt;
  logic         buf_valid;

  assign tgt_pc = i_redirect_pc & ~32'h3;

`ifdef FETCH_JUMP_EN
  assign seq_pc = is_jump(i_imem_data) ? jump_target(fetch_pc_q, i_imem_data)
                                       : fetch_pc_q + 32'd4;
`else
  assign seq_pc = fetch_pc_q + 32'd4;
`endif

  assign pop      = buf_valid && !i_stall;
  assign post_cnt = buf_cnt + 2'd1 - {1'b0, pop};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    push       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_redirect) begin
          fetch_pc_d = tgt_pc;
          state_d    = ST_REQ;
        end else if (buf_cnt < 2'd2) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_redirect) begin
          // an acked word is simply dropped; otherwise the request must drain first
          if (i_imem_ack) begin
            fetch_pc_d = tgt_pc;
          end else begin
            pend_pc_d = tgt_pc;
            state_d   = ST_DROP;
          end
        end else if (i_imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = seq_pc;
          state_d    = (post_cnt < 2'd2) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (i_redirect) pend_pc_d = tgt_pc;
        if (i_imem_ack) begin
          fetch_pc_d = i_redirect ? tgt_pc : pend_pc_q;
          state_d    = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RST_PC;
      pend_pc_q  <= RST_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  fetch_buf #(.RESET_PC(RST_PC)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i ('{ins: i_imem_data, pc: fetch_pc_q}),
    .pop_i       (pop),
    .flush_i     (i_redirect),
    .valid_o     (buf_valid),
    .ins_o       (o_ins),
    .pc_o        (o_pc),
    .count_o     (buf_cnt)
  );

  assign o_imem_req  = (state_q != ST_IDLE);
  assign o_imem_addr = fetch_pc_q;
  assign o_valid     = buf_valid;

endmodule
